// File: rtl/ahb_prior_aging_ctrl_pkg.sv
// rtl/ahb_prior_aging_ctrl_pkg.sv - shared types and defaults for the AHB priority aging controller
package ahb_prior_aging_ctrl_pkg;

    localparam int DEF_PRIOR_LEVEL = 4;

    typedef enum logic [1:0] {
        AG_IDLE,
        AG_WAIT,
        AG_OWN
    } aging_state_t;

endpackage

// File: rtl/ahb_prior_aging_ctrl_if.sv
// rtl/ahb_prior_aging_ctrl_if.sv - request/grant/priority bundle between masters, arbiter and aging controller
interface ahb_prior_aging_ctrl_if #(
    parameter int MASTER_NUM = 2,
    parameter int PRIOR_BIT  = 2,
    parameter int AGE_W      = 4
);
    logic [MASTER_NUM-1:0]                hreq;
    logic [MASTER_NUM-1:0]                hgrant;
    logic [MASTER_NUM-1:0]                trans_done;
    logic [MASTER_NUM-1:0][PRIOR_BIT-1:0] base_prior;
    logic [AGE_W-1:0]                     cfg_age_limit;
    logic [MASTER_NUM-1:0][PRIOR_BIT-1:0] hprior;
    logic [MASTER_NUM-1:0]                starve;

    modport master (
        output hreq, hgrant, trans_done, base_prior, cfg_age_limit,
        input  hprior, starve
    );

    modport slave (
        input  hreq, hgrant, trans_done, base_prior, cfg_age_limit,
        output hprior, starve
    );
endinterface

// File: rtl/ahb_prior_aging_ctrl_cell.sv
// rtl/ahb_prior_aging_ctrl_cell.sv - one master's wait/own FSM with age counter, priority boost and starve flag
module prior_aging_cell
    import ahb_prior_aging_ctrl_pkg::*;
#(
    parameter int PRIOR_LEVEL = DEF_PRIOR_LEVEL,
    parameter int PRIOR_BIT   = $clog2(PRIOR_LEVEL),
    parameter int AGE_W       = 4
) (
    input  logic                 hclk,
    input  logic                 hreset_n,
    input  logic                 i_hreq,
    input  logic                 i_hgrant,
    input  logic                 i_trans_done,
    input  logic [PRIOR_BIT-1:0] i_base_prior,
    input  logic [AGE_W-1:0]     i_cfg_age_limit,
`ifdef AGING_STARVE_CNT_EN
    output logic                 o_starve_set,
`endif
    output logic [PRIOR_BIT-1:0] o_hprior,
    output logic                 o_starve
);
    localparam logic [PRIOR_BIT-1:0] P_MAX = PRIOR_BIT'(PRIOR_LEVEL - 1);

    aging_state_t         r_state, w_state_nxt;
    logic [AGE_W-1:0]     r_age, w_age_nxt;
    logic [PRIOR_BIT-1:0] r_boost, w_boost_nxt;
    logic                 r_starve, w_starve_nxt;
    logic                 r_active;

    logic [PRIOR_BIT-1:0] w_max_boost;
    logic                 w_sat;
    logic                 w_wrap;
    logic [PRIOR_BIT:0]   w_sum;

    assign w_max_boost = (i_base_prior >= P_MAX) ? '0 : P_MAX - i_base_prior;
    assign w_sat       = (r_boost >= w_max_boost);
    // ">=" rather than "==" so a limit shrunk below the current age wraps on the next edge
    assign w_wrap      = (i_cfg_age_limit != '0) && (r_age >= i_cfg_age_limit - AGE_W'(1));

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state  <= AG_IDLE;
            r_age    <= '0;
            r_boost  <= '0;
            r_starve <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_age    <= w_age_nxt;
            r_boost  <= w_boost_nxt;
            r_starve <= w_starve_nxt;
            r_active <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_age_nxt    = r_age;
        w_boost_nxt  = r_boost;
        w_starve_nxt = r_starve;
        case (r_state)
            AG_IDLE: begin
                if (i_hgrant)    w_state_nxt = AG_OWN;
                else if (i_hreq) w_state_nxt = AG_WAIT;
            end
            AG_WAIT: begin
                if (i_hgrant) begin
                    w_state_nxt  = AG_OWN;
                    w_starve_nxt = 1'b0;
                end else if (!i_hreq) begin
                    w_state_nxt  = AG_IDLE;
                    w_age_nxt    = '0;
                    w_boost_nxt  = '0;
                    w_starve_nxt = 1'b0;
                end else if (i_cfg_age_limit != '0) begin
                    if (w_wrap) begin
                        w_age_nxt = '0;
                        if (w_sat) w_starve_nxt = 1'b1;
                        else       w_boost_nxt  = r_boost + PRIOR_BIT'(1);
                    end else begin
                        w_age_nxt = r_age + AGE_W'(1);
                    end
                end
            end
            AG_OWN: begin
                if (i_trans_done) begin
                    w_state_nxt = AG_IDLE;
                    w_age_nxt   = '0;
                    w_boost_nxt = '0;
                end
            end
            default: w_state_nxt = AG_IDLE;
        endcase
    end

    // r_active keeps hprior at zero until the first edge after reset release
    assign w_sum    = {1'b0, i_base_prior} + {1'b0, r_boost};
    assign o_hprior = !r_active ? '0 :
                      (w_sum > {1'b0, P_MAX}) ? P_MAX : w_sum[PRIOR_BIT-1:0];
    assign o_starve = r_starve;
`ifdef AGING_STARVE_CNT_EN
    assign o_starve_set = w_starve_nxt & ~r_starve;
`endif
endmodule

// File: rtl/ahb_prior_aging_ctrl.sv
// rtl/ahb_prior_aging_ctrl.sv - per-slave priority aging controller top; AGING_STARVE_CNT_EN adds a starve event counter
module ahb_prior_aging_ctrl
    import ahb_prior_aging_ctrl_pkg::*;
#(
    parameter int MASTER_NUM  = 2,
    parameter int PRIOR_LEVEL = DEF_PRIOR_LEVEL,
    parameter int PRIOR_BIT   = $clog2(PRIOR_LEVEL),
    parameter int AGE_W       = 4
) (
    input  logic                    hclk,
    input  logic                    hreset_n,
`ifdef AGING_STARVE_CNT_EN
    input  logic                    starve_cnt_clr,
    output logic [15:0]             starve_cnt,
`endif
    ahb_prior_aging_ctrl_if.slave   bus
);
    logic [MASTER_NUM-1:0][PRIOR_BIT-1:0] w_hprior;
    logic [MASTER_NUM-1:0]                w_starve;
`ifdef AGING_STARVE_CNT_EN
    logic [MASTER_NUM-1:0]                w_starve_set;
`endif

    for (genvar g = 0; g < MASTER_NUM; g++) begin : g_cell
        prior_aging_cell #(
            .PRIOR_LEVEL (PRIOR_LEVEL),
            .PRIOR_BIT   (PRIOR_BIT),
            .AGE_W       (AGE_W)
        ) u_cell (
            .hclk            (hclk),
            .hreset_n        (hreset_n),
            .i_hreq          (bus.hreq[g]),
            .i_hgrant        (bus.hgrant[g]),
            .i_trans_done    (bus.trans_done[g]),
            .i_base_prior    (bus.base_prior[g]),
            .i_cfg_age_limit (bus.cfg_age_limit),
`ifdef AGING_STARVE_CNT_EN
            .o_starve_set    (w_starve_set[g]),
`endif
            .o_hprior        (w_hprior[g]),
            .o_starve        (w_starve[g])
        );
    end

    assign bus.hprior = w_hprior;
    assign bus.starve = w_starve;

`ifdef AGING_STARVE_CNT_EN
    logic [15:0] r_starve_cnt;

    // simultaneous set events from several masters count as one
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n)                                 r_starve_cnt <= '0;
        else if (starve_cnt_clr)                       r_starve_cnt <= '0;
        else if (|w_starve_set && (r_starve_cnt != '1)) r_starve_cnt <= r_starve_cnt + 16'd1;
    end

    assign starve_cnt = r_starve_cnt;
`endif
endmodule

// File: tb/tb_ahb_prior_aging_ctrl.sv
// tb/tb_ahb_prior_aging_ctrl.sv - scoreboard bench for ahb_prior_aging_ctrl
module tb_ahb_prior_aging_ctrl;
    localparam int MN = 4;
    localparam int PL = 4;
    localparam int PB = 2;
    localparam int AW = 4;

    logic hclk = 1'b0;
    logic hreset_n = 1'b0;
    always #5 hclk = ~hclk;

    ahb_prior_aging_ctrl_if #(.MASTER_NUM(MN), .PRIOR_BIT(PB), .AGE_W(AW)) bus ();

`ifdef AGING_STARVE_CNT_EN
    logic        starve_cnt_clr;
    logic [15:0] starve_cnt;
`endif

    ahb_prior_aging_ctrl #(
        .MASTER_NUM  (MN),
        .PRIOR_LEVEL (PL),
        .AGE_W       (AW)
    ) u_dut (
        .hclk           (hclk),
        .hreset_n       (hreset_n),
`ifdef AGING_STARVE_CNT_EN
        .starve_cnt_clr (starve_cnt_clr),
        .starve_cnt     (starve_cnt),
`endif
        .bus            (bus.slave)
    );

    typedef struct {
        string      tag;
        logic [7:0] hp;
        logic [3:0] st;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // push the expectation, advance n edges, then compare the popped entry
    task automatic expect_after(input int n, input logic [7:0] hp, input logic [3:0] st, input string tag);
        exp_t e;
        e.tag = tag;
        e.hp  = hp;
        e.st  = st;
        sb.push_back(e);
        repeat (n) @(posedge hclk);
        #1;
        e = sb.pop_front();
        chk({e.tag, "_hprior"}, 32'(bus.hprior), 32'(e.hp));
        chk({e.tag, "_starve"}, 32'(bus.starve), 32'(e.st));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.hreq          = '0;
        bus.hgrant        = '0;
        bus.trans_done    = '0;
        bus.base_prior    = 8'hE4;
        bus.cfg_age_limit = '0;
`ifdef AGING_STARVE_CNT_EN
        starve_cnt_clr = 1'b0;
`endif
        hreset_n = 1'b0;

        expect_after(2, 8'h00, 4'h0, "in_reset");
        hreset_n = 1'b1;
        expect_after(1, 8'hE4, 4'h0, "release");

        // aging to saturation, then starve
        bus.cfg_age_limit = 4'd3;
        bus.hreq = 4'b0001;
        for (int e = 1; e <= 13; e++) begin
            int b;
            b = (e - 1) / 3;
            if (b > 3) b = 3;
            expect_after(1, 8'hE4 | 8'(b), (e >= 13) ? 4'b0001 : 4'b0000, $sformatf("age_e%0d", e));
        end
        bus.hreq = '0;
        expect_after(1, 8'hE4, 4'h0, "withdraw0");

        // grant on the wrap edge, frozen in OWN, release via trans_done
        bus.hreq = 4'b0001;
        expect_after(4, 8'hE5, 4'h0, "t3_boost");
        expect_after(2, 8'hE5, 4'h0, "t3_pre_wrap");
        bus.hgrant = 4'b0001;
        expect_after(1, 8'hE5, 4'h0, "grant_wins");
        bus.hgrant = '0;
        expect_after(4, 8'hE5, 4'h0, "own_frozen");
        bus.trans_done = 4'b0001;
        expect_after(1, 8'hE4, 4'h0, "done_clears");
        bus.trans_done = '0;
        expect_after(1, 8'hE4, 4'h0, "rewait");
        expect_after(3, 8'hE5, 4'h0, "rewait_boost");
        bus.trans_done = 4'b0001;
        expect_after(1, 8'hE5, 4'h0, "done_in_wait_ignored");
        bus.trans_done = '0;
        bus.hreq = '0;
        expect_after(1, 8'hE4, 4'h0, "drop3");

        // master 1 boosted to 2, base change re-clamps, then withdraw
        bus.base_prior = 8'hE0;
        bus.hreq = 4'b0010;
        expect_after(7, 8'hE8, 4'h0, "m1_boost2");
        bus.base_prior = 8'hE8;
        expect_after(0, 8'hEC, 4'h0, "base_clamp");
        bus.base_prior = 8'hE0;
        bus.hreq = '0;
        expect_after(1, 8'hE0, 4'h0, "m1_drop");

        // shrinking the limit below the current age wraps immediately
        bus.base_prior = 8'hE4;
        bus.cfg_age_limit = 4'd8;
        bus.hreq = 4'b0001;
        expect_after(6, 8'hE4, 4'h0, "lim8_age5");
        bus.cfg_age_limit = 4'd3;
        expect_after(1, 8'hE5, 4'h0, "lim_shrink_wrap");
        bus.hreq = '0;
        expect_after(1, 8'hE4, 4'h0, "lim_drop");

        // asynchronous reset mid-operation
        bus.cfg_age_limit = 4'd1;
        bus.hreq = 4'b0001;
        expect_after(2, 8'hE5, 4'h0, "pre_rst_boost");
        hreset_n = 1'b0;
        bus.hreq = '0;
        expect_after(0, 8'h00, 4'h0, "async_rst");
        hreset_n = 1'b1;
        expect_after(1, 8'hE4, 4'h0, "post_rst");

        // aging disabled
        bus.cfg_age_limit = '0;
        bus.hreq = 4'b1111;
        expect_after(25, 8'hE4, 4'h0, "noage_a");
        expect_after(25, 8'hE4, 4'h0, "noage_b");
        bus.hreq = '0;
        expect_after(1, 8'hE4, 4'h0, "noage_drop");

`ifdef AGING_STARVE_CNT_EN
        bus.base_prior = 8'hC0;
        bus.cfg_age_limit = 4'd1;
        bus.hreq = 4'b0101;
        expect_after(5, 8'hF3, 4'b0101, "dual_starve");
        chk("starve_cnt_dual", 32'(starve_cnt), 32'd1);
        expect_after(2, 8'hF3, 4'b0101, "starve_hold");
        chk("starve_cnt_hold", 32'(starve_cnt), 32'd1);
        bus.hreq = '0;
        expect_after(1, 8'hC0, 4'h0, "starve_drop");
        bus.hreq = 4'b0101;
        expect_after(4, 8'hF3, 4'h0, "resat");
        starve_cnt_clr = 1'b1;
        expect_after(1, 8'hF3, 4'b0101, "starve_again");
        chk("starve_cnt_clr_wins", 32'(starve_cnt), 32'd0);
        starve_cnt_clr = 1'b0;
        bus.hreq = '0;
        expect_after(1, 8'hC0, 4'h0, "cnt_drop");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
